// File: rtl/sad_engine_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : sad_engine_if
// Purpose : Memory read ports and result write port of the SAD engine.
// Revision: 1.0
// ============================================================================
interface sad_engine_if #(
    parameter int D_WIDTH = 8,
    parameter int LANES   = 4,
    parameter int A_WIDTH = 13,
    parameter int C_WIDTH = 7,
    parameter int S_WIDTH = 32
);
    logic [A_WIDTH-1:0]         A_Addr;
    logic [A_WIDTH-1:0]         B_Addr;
    logic [D_WIDTH*LANES-1:0]   A_Data;
    logic [D_WIDTH*LANES-1:0]   B_Data;
    logic                       I_En;
    logic                       I_RW;
    logic [C_WIDTH-1:0]         C_Addr;
    logic [S_WIDTH-1:0]         SAD_Out;
    logic                       O_En;
    logic                       O_RW;

    modport master (
        output A_Addr, B_Addr, I_En, I_RW, C_Addr, SAD_Out, O_En, O_RW,
        input  A_Data, B_Data
    );

    modport slave (
        input  A_Addr, B_Addr, I_En, I_RW, C_Addr, SAD_Out, O_En, O_RW,
        output A_Data, B_Data
    );
endinterface
`default_nettype wire

// File: rtl/sad_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : sad_engine
// Purpose : Per-block sum of absolute/squared differences with running minimum.
// Revision: 1.0
// ============================================================================
module sad_engine #(
    parameter int D_WIDTH   = 8,
    parameter int LANES     = 4,
    parameter int BLK_WORDS = 64,
    parameter int NUM_BLKS  = 128,
    parameter int A_WIDTH   = 13,
    parameter int C_WIDTH   = 7,
    parameter int S_WIDTH   = 32
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Go,
    input  logic                Mode,
    input  logic                Abort,
    sad_engine_if.master        mem,
    output logic                Busy,
    output logic                Done,
    output logic [S_WIDTH-1:0]  Min_Out,
    output logic [C_WIDTH-1:0]  Min_Idx
);

    localparam int c_LANE_W = 2 * D_WIDTH;
    localparam int c_WSUM_W = 2 * D_WIDTH + $clog2(LANES) + 1;
    localparam int c_EXT_W  = ((S_WIDTH > c_WSUM_W) ? S_WIDTH : c_WSUM_W) + 1;
    localparam int c_CNT_W  = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BLK_WORDS - 1);
    localparam logic [C_WIDTH-1:0] c_BLK_LAST = C_WIDTH'(NUM_BLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_ACC   = 3'd4,
        S_WRITE = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t               r_state;
    logic                 r_mode;
    logic [A_WIDTH-1:0]   r_waddr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [C_WIDTH-1:0]   r_blk;
    logic [S_WIDTH-1:0]   r_sum;
    logic [A_WIDTH-1:0]   r_a_addr;
    logic                 r_i_en;
    logic [C_WIDTH-1:0]   r_c_addr;
    logic [S_WIDTH-1:0]   r_sad_out;
    logic                 r_o_en;
    logic                 r_busy;
    logic                 r_done;
    logic [S_WIDTH-1:0]   r_min;
    logic [C_WIDTH-1:0]   r_min_idx;

    logic [c_LANE_W-1:0]  w_lane_val [LANES];
    logic [c_WSUM_W-1:0]  w_word_sum;
    logic [c_EXT_W-1:0]   w_total;
    logic [S_WIDTH-1:0]   w_sum_next;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [D_WIDTH-1:0]  w_a;
        logic [D_WIDTH-1:0]  w_b;
        logic [D_WIDTH-1:0]  w_diff;
        logic [c_LANE_W-1:0] w_dx;
        assign w_a           = mem.A_Data[k*D_WIDTH +: D_WIDTH];
        assign w_b           = mem.B_Data[k*D_WIDTH +: D_WIDTH];
        assign w_diff        = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
        assign w_dx          = {{D_WIDTH{1'b0}}, w_diff};
        assign w_lane_val[k] = r_mode ? (w_dx * w_dx) : w_dx;
    end

    always_comb begin
        w_word_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_word_sum = w_word_sum + c_WSUM_W'(w_lane_val[k]);
        end
    end

    // Accumulate one bit wider than either operand so overflow is visible and clamps.
    assign w_total    = c_EXT_W'(r_sum) + c_EXT_W'(w_word_sum);
    assign w_sum_next = (|w_total[c_EXT_W-1:S_WIDTH]) ? {S_WIDTH{1'b1}} : w_total[S_WIDTH-1:0];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_waddr   <= '0;
            r_cnt     <= '0;
            r_blk     <= '0;
            r_sum     <= '0;
            r_a_addr  <= '0;
            r_i_en    <= 1'b0;
            r_c_addr  <= '0;
            r_sad_out <= '0;
            r_o_en    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_min     <= '1;
            r_min_idx <= '0;
        end else begin
            r_i_en <= 1'b0;
            r_o_en <= 1'b0;
            r_done <= 1'b0;
            if (Abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (Go) begin
                            r_state   <= S_INIT;
                            r_busy    <= 1'b1;
                            r_mode    <= Mode;
                            r_waddr   <= '0;
                            r_blk     <= '0;
                            r_min     <= '1;
                            r_min_idx <= '0;
                        end
                    end
                    S_INIT: begin
                        r_sum    <= '0;
                        r_cnt    <= '0;
                        r_a_addr <= r_waddr;
                        r_i_en   <= 1'b1;
                        r_state  <= S_READ;
                    end
                    S_READ:  r_state <= S_WAIT;
                    S_WAIT:  r_state <= S_ACC;
                    S_ACC: begin
                        r_sum   <= w_sum_next;
                        r_waddr <= r_waddr + A_WIDTH'(1);
                        r_cnt   <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == c_CNT_LAST) begin
                            // Result and minimum are registered so they are visible during WRITE.
                            r_state   <= S_WRITE;
                            r_o_en    <= 1'b1;
                            r_c_addr  <= r_blk;
                            r_sad_out <= w_sum_next;
                            if (w_sum_next < r_min) begin
                                r_min     <= w_sum_next;
                                r_min_idx <= r_blk;
                            end
                        end else begin
                            r_state  <= S_READ;
                            r_a_addr <= r_waddr + A_WIDTH'(1);
                            r_i_en   <= 1'b1;
                        end
                    end
                    S_WRITE: begin
                        if (r_blk == c_BLK_LAST) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_blk   <= r_blk + C_WIDTH'(1);
                            r_state <= S_INIT;
                        end
                    end
                    S_FIN: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem.A_Addr  = r_a_addr;
    assign mem.B_Addr  = r_a_addr;
    assign mem.I_En    = r_i_en;
    assign mem.I_RW    = 1'b0;
    assign mem.C_Addr  = r_c_addr;
    assign mem.SAD_Out = r_sad_out;
    assign mem.O_En    = r_o_en;
    assign mem.O_RW    = r_o_en;
    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Min_Out     = r_min;
    assign Min_Idx     = r_min_idx;

endmodule
`default_nettype wire

// File: tb/tb_sad_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_sad_engine
// Purpose : Scoreboard bench for sad_engine (4 lanes, 4 words, 2 blocks).
// Revision: 1.0
// ============================================================================
module tb_sad_engine;
    localparam int DW = 8, LN = 4, BW = 4, NB = 2, AW = 13, CW = 7, SW = 32, SWS = 10;

    logic clk = 1'b0, rst_n = 1'b0;
    logic go = 1'b0, mode = 1'b0, abort = 1'b0, sat_go = 1'b0, sat_mode = 1'b0;
    logic busy, done, sat_busy, sat_done;
    logic [SW-1:0]  min_out;
    logic [CW-1:0]  min_idx;
    logic [SWS-1:0] sat_min_out;
    logic [CW-1:0]  sat_min_idx;

    sad_engine_if #(.D_WIDTH(DW), .LANES(LN), .A_WIDTH(AW), .C_WIDTH(CW), .S_WIDTH(SW))  bus ();
    sad_engine_if #(.D_WIDTH(DW), .LANES(LN), .A_WIDTH(AW), .C_WIDTH(CW), .S_WIDTH(SWS)) sbus ();

    sad_engine #(.D_WIDTH(DW), .LANES(LN), .BLK_WORDS(BW), .NUM_BLKS(NB), .A_WIDTH(AW),
                 .C_WIDTH(CW), .S_WIDTH(SW)) u_dut (
        .Clk(clk), .Rst(rst_n), .Go(go), .Mode(mode), .Abort(abort), .mem(bus),
        .Busy(busy), .Done(done), .Min_Out(min_out), .Min_Idx(min_idx));

    sad_engine #(.D_WIDTH(DW), .LANES(LN), .BLK_WORDS(BW), .NUM_BLKS(NB), .A_WIDTH(AW),
                 .C_WIDTH(CW), .S_WIDTH(SWS)) u_sat (
        .Clk(clk), .Rst(rst_n), .Go(sat_go), .Mode(sat_mode), .Abort(1'b0), .mem(sbus),
        .Busy(sat_busy), .Done(sat_done), .Min_Out(sat_min_out), .Min_Idx(sat_min_idx));

    always #5 clk = ~clk;

    logic [31:0] ma0 [8];
    logic [31:0] mb0 [8];
    logic [31:0] ma1 [8];
    logic [31:0] mb1 [8];

    // Synchronous-read memories: data appears one cycle after the enabled read.
    always @(posedge clk) begin
        if (bus.I_En) begin
            bus.A_Data <= ma0[bus.A_Addr[2:0]];
            bus.B_Data <= mb0[bus.B_Addr[2:0]];
        end
        if (sbus.I_En) begin
            sbus.A_Data <= ma1[sbus.A_Addr[2:0]];
            sbus.B_Data <= mb1[sbus.B_Addr[2:0]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    int          exp_addr [$];
    logic [31:0] exp_sad  [$];
    int          obs_addr [$];
    logic [31:0] obs_sad  [$];
    int          obs_cyc  [$];
    int          ien_addr [$];
    int          ien_cnt, done_cnt, done_cyc, rw_bad, addr_bad;
    int          ea, oa;
    logic [31:0] es, os;

    function automatic logic [31:0] model_blk(input bit sat, input bit ssd, input int blk);
        longint s   = 0;
        longint lim = sat ? longint'(1023) : longint'(32'hFFFF_FFFF);
        logic [31:0] a, b;
        int av, bv, d;
        for (int w = 0; w < BW; w++) begin
            a = sat ? ma1[blk*BW+w] : ma0[blk*BW+w];
            b = sat ? mb1[blk*BW+w] : mb0[blk*BW+w];
            for (int k = 0; k < LN; k++) begin
                av = int'(a[k*DW +: DW]);
                bv = int'(b[k*DW +: DW]);
                d  = (av > bv) ? (av - bv) : (bv - av);
                s  = s + (ssd ? longint'(d * d) : longint'(d));
                if (s > lim) s = lim;
            end
        end
        return 32'(s);
    endfunction

    task automatic fill(input bit sat, input int blk, input logic [7:0] av, input logic [7:0] bv);
        for (int w = 0; w < BW; w++) begin
            if (sat) begin
                ma1[blk*BW+w] = {4{av}};
                mb1[blk*BW+w] = {4{bv}};
            end else begin
                ma0[blk*BW+w] = {4{av}};
                mb0[blk*BW+w] = {4{bv}};
            end
        end
    endtask

    task automatic push_run(input bit sat, input bit ssd, input int nblk);
        for (int b = 0; b < nblk; b++) begin
            exp_addr.push_back(b);
            exp_sad.push_back(model_blk(sat, ssd, b));
        end
    endtask

    task automatic clear_obs();
        repeat (2) @(negedge clk);
        obs_addr.delete(); obs_sad.delete(); obs_cyc.delete(); ien_addr.delete();
        exp_addr.delete(); exp_sad.delete();
        ien_cnt = 0; done_cnt = 0; done_cyc = 0; rw_bad = 0; addr_bad = 0;
    endtask

    // Records DUT activity once per cycle on the falling edge; returns on Done or budget.
    task automatic watch(input int max_cycles, input bit sat, input bit stop_on_done);
        logic s_oen, s_orw, s_ien, s_irw, s_done;
        int   s_caddr, s_aaddr, s_baddr;
        logic [31:0] s_sad;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (sat) begin
                s_oen = sbus.O_En; s_orw = sbus.O_RW; s_ien = sbus.I_En; s_irw = sbus.I_RW;
                s_done = sat_done; s_caddr = int'(sbus.C_Addr); s_sad = 32'(sbus.SAD_Out);
                s_aaddr = int'(sbus.A_Addr); s_baddr = int'(sbus.B_Addr);
            end else begin
                s_oen = bus.O_En; s_orw = bus.O_RW; s_ien = bus.I_En; s_irw = bus.I_RW;
                s_done = done; s_caddr = int'(bus.C_Addr); s_sad = bus.SAD_Out;
                s_aaddr = int'(bus.A_Addr); s_baddr = int'(bus.B_Addr);
            end
            if (s_oen) begin
                obs_addr.push_back(s_caddr);
                obs_sad.push_back(s_sad);
                obs_cyc.push_back(cyc);
                if (s_orw !== 1'b1) rw_bad++;
            end
            if (s_ien) begin
                ien_cnt++;
                ien_addr.push_back(s_aaddr);
                if (s_aaddr != s_baddr || s_irw !== 1'b0) addr_bad++;
            end
            if (s_done) begin
                done_cnt++;
                done_cyc = cyc;
                if (stop_on_done) break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (bus.I_En !== 1'b0 || bus.O_En !== 1'b0 || bus.O_RW !== 1'b0)
            begin n_fail++; $display("FAIL reset_strobes: got %b%b%b expected 000", bus.I_En, bus.O_En, bus.O_RW); end
        n_checks++; if (min_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_min_out: got %h expected ffffffff", min_out); end
        n_checks++; if (sat_min_out !== 10'h3FF)   begin n_fail++; $display("FAIL reset_sat_min_out: got %h expected 3ff", sat_min_out); end
        n_checks++; if (min_idx !== 7'd0)  begin n_fail++; $display("FAIL reset_min_idx: got %0d expected 0", min_idx); end
        n_checks++; if (bus.SAD_Out !== 32'd0 || bus.C_Addr !== 7'd0 || bus.A_Addr !== 13'd0)
            begin n_fail++; $display("FAIL reset_outputs: got sad %0d caddr %0d aaddr %0d expected 0 0 0", bus.SAD_Out, bus.C_Addr, bus.A_Addr); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sad();
        clear_obs();
        fill(0, 0, 8'h0A, 8'h03); fill(0, 1, 8'h0A, 8'h03);
        mode = 1'b0;
        push_run(0, 0, NB);
        go = 1'b1; @(negedge clk); go = 1'b0;
        watch(100, 0, 1);
        n_checks++; if (obs_cyc.size() < 2 || (obs_cyc[1] - obs_cyc[0]) != 14)
            begin n_fail++; $display("FAIL sad_write_spacing: got %0d writes expected 2 writes 14 apart", obs_cyc.size()); end
        n_checks++; if (done_cnt != 1 || obs_cyc.size() < 2 || done_cyc != obs_cyc[obs_cyc.size()-1] + 1)
            begin n_fail++; $display("FAIL sad_done: got count %0d at %0d expected 1 right after last write", done_cnt, done_cyc); end
        n_checks++; if (ien_cnt != 8 || addr_bad != 0 || rw_bad != 0)
            begin n_fail++; $display("FAIL sad_strobes: got reads %0d bad %0d/%0d expected 8 0/0", ien_cnt, addr_bad, rw_bad); end
        for (int i = 0; i < ien_addr.size(); i++) begin
            n_checks++; if (ien_addr[i] != i) begin n_fail++; $display("FAIL sad_read_addr: got %0d expected %0d", ien_addr[i], i); end
        end
        n_checks++;
        if (obs_sad.size() != exp_sad.size()) begin n_fail++; $display("FAIL sad_write_count: got %0d expected %0d", obs_sad.size(), exp_sad.size()); end
        while (exp_sad.size() > 0 && obs_sad.size() > 0) begin
            ea = exp_addr.pop_front(); es = exp_sad.pop_front(); oa = obs_addr.pop_front(); os = obs_sad.pop_front();
            n_checks++; if (oa !== ea || os !== es) begin n_fail++; $display("FAIL sad_write: got addr %0d sum %0d expected addr %0d sum %0d", oa, os, ea, es); end
        end
        n_checks++; if (min_out !== 32'd112 || min_idx !== 7'd0)
            begin n_fail++; $display("FAIL sad_min: got %0d idx %0d expected 112 idx 0", min_out, min_idx); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL sad_idle: got busy %b done %b expected 0 0", busy, done); end
    endtask

    task automatic test_ssd();
        clear_obs();
        fill(0, 0, 8'h0A, 8'h03); fill(0, 1, 8'h0A, 8'h03);
        mode = 1'b1;
        push_run(0, 1, NB);
        go = 1'b1; @(negedge clk); go = 1'b0;
        mode = 1'b0;  // must not affect the run in progress
        watch(100, 0, 1);
        n_checks++;
        if (obs_sad.size() != exp_sad.size()) begin n_fail++; $display("FAIL ssd_write_count: got %0d expected %0d", obs_sad.size(), exp_sad.size()); end
        while (exp_sad.size() > 0 && obs_sad.size() > 0) begin
            ea = exp_addr.pop_front(); es = exp_sad.pop_front(); oa = obs_addr.pop_front(); os = obs_sad.pop_front();
            n_checks++; if (oa !== ea || os !== es) begin n_fail++; $display("FAIL ssd_write: got addr %0d sum %0d expected addr %0d sum %0d", oa, os, ea, es); end
        end
        n_checks++; if (min_out !== 32'd784 || min_idx !== 7'd0)
            begin n_fail++; $display("FAIL ssd_tie_min: got %0d idx %0d expected 784 idx 0", min_out, min_idx); end

        clear_obs();
        fill(0, 1, 8'h0A, 8'h0A);
        mode = 1'b1;
        push_run(0, 1, NB);
        go = 1'b1; @(negedge clk); go = 1'b0;
        watch(100, 0, 1);
        n_checks++;
        if (obs_sad.size() != exp_sad.size()) begin n_fail++; $display("FAIL ssd2_write_count: got %0d expected %0d", obs_sad.size(), exp_sad.size()); end
        while (exp_sad.size() > 0 && obs_sad.size() > 0) begin
            ea = exp_addr.pop_front(); es = exp_sad.pop_front(); oa = obs_addr.pop_front(); os = obs_sad.pop_front();
            n_checks++; if (oa !== ea || os !== es) begin n_fail++; $display("FAIL ssd2_write: got addr %0d sum %0d expected addr %0d sum %0d", oa, os, ea, es); end
        end
        n_checks++; if (min_out !== 32'd0 || min_idx !== 7'd1)
            begin n_fail++; $display("FAIL ssd2_min: got %0d idx %0d expected 0 idx 1", min_out, min_idx); end
    endtask

    task automatic test_saturation();
        clear_obs();
        fill(1, 0, 8'hFF, 8'h00); fill(1, 1, 8'hFF, 8'h00);
        sat_mode = 1'b1;
        push_run(1, 1, NB);
        sat_go = 1'b1; @(negedge clk); sat_go = 1'b0;
        watch(100, 1, 1);
        n_checks++;
        if (obs_sad.size() != exp_sad.size()) begin n_fail++; $display("FAIL sat_write_count: got %0d expected %0d", obs_sad.size(), exp_sad.size()); end
        while (exp_sad.size() > 0 && obs_sad.size() > 0) begin
            ea = exp_addr.pop_front(); es = exp_sad.pop_front(); oa = obs_addr.pop_front(); os = obs_sad.pop_front();
            n_checks++; if (oa !== ea || os !== es) begin n_fail++; $display("FAIL sat_write: got addr %0d sum %0d expected addr %0d sum %0d", oa, os, ea, es); end
        end
        n_checks++; if (sat_min_out !== 10'd1023 || sat_min_idx !== 7'd0 || done_cnt != 1)
            begin n_fail++; $display("FAIL sat_min: got %0d idx %0d done %0d expected 1023 idx 0 done 1", sat_min_out, sat_min_idx, done_cnt); end
        @(negedge clk);
        n_checks++; if (sat_busy !== 1'b0) begin n_fail++; $display("FAIL sat_idle: got busy %b expected 0", sat_busy); end
    endtask

    task automatic test_abort();
        clear_obs();
        fill(0, 0, 8'h0A, 8'h03); fill(0, 1, 8'h0A, 8'h03);
        mode = 1'b0;
        push_run(0, 0, 1);
        go = 1'b1; @(negedge clk); go = 1'b0;
        watch(17, 0, 0);  // ends in the ACC cycle of the first word of block 1
        n_checks++; if (ien_cnt != 5 || busy !== 1'b1)
            begin n_fail++; $display("FAIL abort_pre: got reads %0d busy %b expected 5 1", ien_cnt, busy); end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || bus.I_En !== 1'b0 || bus.O_En !== 1'b0)
            begin n_fail++; $display("FAIL abort_idle: got busy %b ien %b oen %b expected 0 0 0", busy, bus.I_En, bus.O_En); end
        watch(40, 0, 0);
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt); end
        n_checks++;
        if (obs_sad.size() != exp_sad.size()) begin n_fail++; $display("FAIL abort_write_count: got %0d expected %0d", obs_sad.size(), exp_sad.size()); end
        while (exp_sad.size() > 0 && obs_sad.size() > 0) begin
            ea = exp_addr.pop_front(); es = exp_sad.pop_front(); oa = obs_addr.pop_front(); os = obs_sad.pop_front();
            n_checks++; if (oa !== ea || os !== es) begin n_fail++; $display("FAIL abort_write: got addr %0d sum %0d expected addr %0d sum %0d", oa, os, ea, es); end
        end
        n_checks++; if (min_out !== 32'd112 || min_idx !== 7'd0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL abort_min: got %0d idx %0d busy %b expected 112 idx 0 busy 0", min_out, min_idx, busy); end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        fill(0, 0, 8'h0A, 8'h03); fill(0, 1, 8'h0A, 8'h03);
        mode = 1'b0;
        go = 1'b1; @(negedge clk); go = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.I_En !== 1'b1) begin n_fail++; $display("FAIL rstmid_read: got ien %b expected 1", bus.I_En); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.I_En !== 1'b0 || busy !== 1'b0 || min_out !== 32'hFFFF_FFFF)
            begin n_fail++; $display("FAIL rstmid_async: got ien %b busy %b min %h expected 0 0 ffffffff", bus.I_En, busy, min_out); end
        @(negedge clk);
        push_run(0, 0, NB);
        rst_n = 1'b1; go = 1'b1;
        @(negedge clk); go = 1'b0;
        watch(100, 0, 1);
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rstmid_done: got %0d expected 1", done_cnt); end
        n_checks++;
        if (obs_sad.size() != exp_sad.size()) begin n_fail++; $display("FAIL rstmid_write_count: got %0d expected %0d", obs_sad.size(), exp_sad.size()); end
        while (exp_sad.size() > 0 && obs_sad.size() > 0) begin
            ea = exp_addr.pop_front(); es = exp_sad.pop_front(); oa = obs_addr.pop_front(); os = obs_sad.pop_front();
            n_checks++; if (oa !== ea || os !== es) begin n_fail++; $display("FAIL rstmid_write: got addr %0d sum %0d expected addr %0d sum %0d", oa, os, ea, es); end
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        fill(0, 0, 8'h0A, 8'h03); fill(0, 1, 8'h0A, 8'h03);
        mode = 1'b0;
        push_run(0, 0, NB);
        push_run(0, 0, NB);
        go = 1'b1;
        watch(100, 0, 1);
        n_checks++; if (obs_sad.size() != 2 || done_cnt != 1)
            begin n_fail++; $display("FAIL b2b_first_run: got %0d writes %0d done expected 2 1", obs_sad.size(), done_cnt); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got busy %b expected 0", busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got busy %b expected 1", busy); end
        go = 1'b0;
        watch(100, 0, 1);
        n_checks++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done: got %0d expected 2", done_cnt); end
        n_checks++;
        if (obs_sad.size() != exp_sad.size()) begin n_fail++; $display("FAIL b2b_write_count: got %0d expected %0d", obs_sad.size(), exp_sad.size()); end
        while (exp_sad.size() > 0 && obs_sad.size() > 0) begin
            ea = exp_addr.pop_front(); es = exp_sad.pop_front(); oa = obs_addr.pop_front(); os = obs_sad.pop_front();
            n_checks++; if (oa !== ea || os !== es) begin n_fail++; $display("FAIL b2b_write: got addr %0d sum %0d expected addr %0d sum %0d", oa, os, ea, es); end
        end
    endtask

    initial begin
        test_reset();
        test_sad();
        test_ssd();
        test_saturation();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sad_engine.md
SAD_ENGINE -- requirements
Module: sad_engine

Interface
REQ-001 SHALL have parameters: D_WIDTH (8) pixel bits; LANES (4) pixels per memory word; BLK_WORDS (64) words per block; NUM_BLKS (128) blocks per run; A_WIDTH (13) input address bits; C_WIDTH (7) output address bits; S_WIDTH (32) sum bits.
REQ-002 SHALL have one clock and asynchronous active-low reset, ports: Clk in 1, clock; Rst in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: Go in 1 start; Mode in 1 (0=SAD, 1=SSD); Abort in 1 cancel run.
REQ-004 SHALL have ports: A_Addr, B_Addr out A_WIDTH word address; A_Data, B_Data in D_WIDTH*LANES, lane k = bits [k*D_WIDTH +: D_WIDTH].
REQ-005 SHALL have ports: I_En, I_RW out 1 input memory enable/read-write (I_RW always 0).
REQ-006 SHALL have ports: C_Addr out C_WIDTH; SAD_Out out S_WIDTH; O_En, O_RW out 1 result write strobe.
REQ-007 SHALL have ports: Busy out 1; Done out 1; Min_Out out S_WIDTH; Min_Idx out C_WIDTH.

Function
REQ-008 SHALL implement states IDLE, INIT, READ, WAIT, ACC, WRITE, FIN.
REQ-009 IDLE: Go=1 -> INIT, latch Mode, clear word address, block index, Min_Out to all-ones, Min_Idx to 0; Go otherwise ignored.
REQ-010 INIT: clear Sum and word counter -> READ.
REQ-011 READ: drive A_Addr=B_Addr=word address, I_En=1 for exactly this cycle -> WAIT.
REQ-012 WAIT: one-cycle memory latency, I_En=0 -> ACC; data valid on A_Data/B_Data in ACC.
REQ-013 ACC: Sum += sum over LANES of |a-b| (Mode 0) or (a-b)^2 (Mode 1), unsigned; increment word address and counter; counter==BLK_WORDS-1 -> WRITE, else READ.
REQ-014 Sum SHALL saturate at 2^S_WIDTH-1, never wrap.
REQ-015 WRITE: O_En=O_RW=1 for exactly one cycle, C_Addr=block index, SAD_Out=Sum (registered, held until next WRITE).
REQ-016 WRITE: if Sum < Min_Out (strict) update Min_Out=Sum, Min_Idx=block index; ties keep earlier index.
REQ-017 WRITE: block index==NUM_BLKS-1 -> FIN, else increment block index -> INIT.
REQ-018 FIN: Done=1 for exactly one cycle -> IDLE.
REQ-019 Block latency SHALL be 3*BLK_WORDS+2 cycles (INIT through WRITE); Done asserted the cycle after last WRITE.
REQ-020 Busy SHALL be 1 in every state except IDLE.
REQ-021 Abort=1 in any non-IDLE state SHALL return to IDLE next cycle, no WRITE, no Done; Abort has priority over all transitions; Min_Out/Min_Idx keep partial values.
REQ-022 Word address SHALL wrap to 0 after 2^A_WIDTH-1 without error.
REQ-023 Outside stated cycles I_En, O_En, O_RW, Done SHALL be 0 and A_Addr, B_Addr, C_Addr hold last driven value.
REQ-024 Mode change while Busy SHALL have no effect until next Go.

Reset
REQ-025 Rst=0 SHALL immediately force IDLE and all outputs, Sum, counters to 0, except Min_Out to all-ones.
REQ-026 Rst asserted mid-run SHALL abandon the run, no WRITE or Done after release.
REQ-027 Go sampled in first cycle after Rst release SHALL be honoured.

Verification (bench: LANES=4, BLK_WORDS=4, NUM_BLKS=2, D_WIDTH=8)
REQ-028 SAD: A words all 0x0A, B all 0x03, Go pulse -> two WRITEs SAD_Out=112 at C_Addr 0,1, 14 cycles apart, Done once, Min_Out=112, Min_Idx=0.
REQ-029 SSD: same data, Mode=1 -> SAD_Out=784 per block; block 1 B=0x0A -> 784 then 0, Min_Idx=1.
REQ-030 Saturation: S_WIDTH=10, Mode=1, A=0xFF, B=0x00 -> SAD_Out=1023.
REQ-031 Abort asserted in ACC of block 1 -> IDLE next cycle, one WRITE only, Done never 1, Busy=0.
REQ-032 Rst low during READ of block 0 -> I_En=0, Busy=0 immediately; after release Go gives full two-block run.
REQ-033 Go held high throughout run -> second run starts only from IDLE after Done; Go pulses while Busy ignored.
